// File: rtl/nios_mult_cell_pipe.sv
// nios_mult_cell_pipe
// Pipelined DATA_W x DATA_W multiplier cell producing the full 2*DATA_W product.
// Each operand is independently signed or unsigned, which covers mul, mulxuu,
// mulxsu and mulxss in one cell.
//
// Stage 1 registers four half-width partial products. Stage 2 sums them.
// With PIPE_STAGES=3 an extra output register follows the sum.
//
// Optional feature: define NIOS_MULT_CELL_MAC_EN to add the mac/acc_clr ports
// and a 2*DATA_W accumulator. The accumulate happens in the final stage.
//
// Valid/enable semantics: an operation is accepted when in_valid=1 on a clock
// edge where ena=1. It is presented as out_valid=1 after exactly PIPE_STAGES
// enabled edges. While ena=0 every register holds, including all valid bits.
// Outputs stay stable, and in_valid is ignored.

module nios_mult_cell_pipe #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ena,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              sign_a,
  input  logic              sign_b,
`ifdef NIOS_MULT_CELL_MAC_EN
  input  logic              mac,
  input  logic              acc_clr,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] result_lo,
  output logic [DATA_W-1:0] result_hi,
  output logic              busy
);

  localparam int H  = DATA_W / 2;
  // A partial product of two (H+1)-bit signed-or-zero-extended halves fits in 2H+2 bits.
  localparam int PW = 2 * H + 2;
  localparam int RW = 2 * DATA_W;

  // Reject illegal configurations at elaboration time.
  generate
    if ((DATA_W < 8) || (DATA_W > 64) || ((DATA_W % 2) != 0)) begin : g_bad_data_w
      $error("nios_mult_cell_pipe: DATA_W must be even and within 8..64");
    end
    if ((PIPE_STAGES != 2) && (PIPE_STAGES != 3)) begin : g_bad_pipe
      $error("nios_mult_cell_pipe: PIPE_STAGES must be 2 or 3");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Operand split.
  // Low halves are always unsigned.
  // A high half is sign-extended only when that operand is signed. This matches
  // the (DATA_W+1)-bit extension of the whole operand.
  // All halves are widened to PW bits, so a PW-bit multiply is exact.
  // ---------------------------------------------------------------------------
  logic          a_ext;
  logic          b_ext;
  logic [PW-1:0] a_lo_w;
  logic [PW-1:0] a_hi_w;
  logic [PW-1:0] b_lo_w;
  logic [PW-1:0] b_hi_w;

  assign a_ext  = sign_a & src1[DATA_W-1];
  assign b_ext  = sign_b & src2[DATA_W-1];
  assign a_lo_w = {{(PW-H){1'b0}}, src1[H-1:0]};
  assign a_hi_w = {{(PW-H){a_ext}}, src1[DATA_W-1:H]};
  assign b_lo_w = {{(PW-H){1'b0}}, src2[H-1:0]};
  assign b_hi_w = {{(PW-H){b_ext}}, src2[DATA_W-1:H]};

  logic [PW-1:0] ll_q;
  logic [PW-1:0] lh_q;
  logic [PW-1:0] hl_q;
  logic [PW-1:0] hh_q;
  logic          v1_q;
`ifdef NIOS_MULT_CELL_MAC_EN
  logic          m1_q;
`endif

  // Stage 1: register the four partial products and the valid tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ll_q <= '0;
      lh_q <= '0;
      hl_q <= '0;
      hh_q <= '0;
      v1_q <= 1'b0;
`ifdef NIOS_MULT_CELL_MAC_EN
      m1_q <= 1'b0;
`endif
    end else if (ena) begin
      ll_q <= a_lo_w * b_lo_w;
      lh_q <= a_lo_w * b_hi_w;
      hl_q <= a_hi_w * b_lo_w;
      hh_q <= a_hi_w * b_hi_w;
      v1_q <= in_valid;
`ifdef NIOS_MULT_CELL_MAC_EN
      m1_q <= mac;
`endif
    end
  end

  // Sign-extend a partial product to the full result width.
  function automatic logic [RW-1:0] sext(input logic [PW-1:0] p);
    return {{(RW-PW){p[PW-1]}}, p};
  endfunction

  // Weighted sum of the partial products, taken modulo 2^(2*DATA_W).
  logic [RW-1:0] sum_c;
  assign sum_c = sext(ll_q)
               + (sext(lh_q) << H)
               + (sext(hl_q) << H)
               + (sext(hh_q) << DATA_W);

  // ---------------------------------------------------------------------------
  // Feed into the final (output) register.
  // With PIPE_STAGES=2 the sum goes straight into the output register.
  // With PIPE_STAGES=3 an intermediate sum register sits in between.
  // ---------------------------------------------------------------------------
  logic [RW-1:0] fin_d;
  logic          fin_v;
  logic          mid_busy;
`ifdef NIOS_MULT_CELL_MAC_EN
  logic          fin_m;
`endif

  generate
    if (PIPE_STAGES == 3) begin : g_mid
      logic [RW-1:0] s2_q;
      logic          v2_q;
`ifdef NIOS_MULT_CELL_MAC_EN
      logic          m2_q;
`endif

      // Intermediate stage: hold the summed product and its valid tag.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s2_q <= '0;
          v2_q <= 1'b0;
`ifdef NIOS_MULT_CELL_MAC_EN
          m2_q <= 1'b0;
`endif
        end else if (ena) begin
          s2_q <= sum_c;
          v2_q <= v1_q;
`ifdef NIOS_MULT_CELL_MAC_EN
          m2_q <= m1_q;
`endif
        end
      end

      assign fin_d    = s2_q;
      assign fin_v    = v2_q;
      assign mid_busy = v2_q;
`ifdef NIOS_MULT_CELL_MAC_EN
      assign fin_m    = m2_q;
`endif
    end else begin : g_no_mid
      assign fin_d    = sum_c;
      assign fin_v    = v1_q;
      assign mid_busy = 1'b0;
`ifdef NIOS_MULT_CELL_MAC_EN
      assign fin_m    = m1_q;
`endif
    end
  endgenerate

  logic [RW-1:0] out_d;

`ifdef NIOS_MULT_CELL_MAC_EN
  logic [RW-1:0] acc_q;
  logic          mac_hit;

  // A completing mac op accumulates unless acc_clr wins in the same cycle.
  assign mac_hit = fin_v & fin_m & ~acc_clr;
  assign out_d   = mac_hit ? (acc_q + fin_d) : fin_d;

  // Accumulator: clear has priority; otherwise capture the accumulated result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (ena) begin
      if (acc_clr) begin
        acc_q <= '0;
      end else if (mac_hit) begin
        acc_q <= out_d;
      end
    end
  end
`else
  assign out_d = fin_d;
`endif

  logic [RW-1:0] res_q;

  // Final stage: output register and out_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q     <= '0;
      out_valid <= 1'b0;
    end else if (ena) begin
      res_q     <= out_d;
      out_valid <= fin_v;
    end
  end

  assign result_lo = res_q[DATA_W-1:0];
  assign result_hi = res_q[RW-1:DATA_W];
  assign busy      = v1_q | mid_busy | out_valid;

endmodule
